joybus_device: RTL and testbench
================================

JOYBUS_DEVICE -- requirements
Module: joybus_device

Interface
REQ-001 SHALL have parameter: CLK_FREQ_HZ, 50_000_000, system clock frequency; US_CYC = CLK_FREQ_HZ/1_000_000 cycles per microsecond.
REQ-002 SHALL have port: clk  input  1  single system clock, all logic on rising edge.
REQ-003 SHALL have port: rst_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port: JB  inout  1  open-drain JOYBUS line; driven 1'b0 when asserting, 'z otherwise, never driven high.
REQ-005 SHALL have port: cntlr_data  input  32  button/stick word returned for a poll command, MSB sent first.
REQ-006 SHALL have port: cmd_valid  output  1  one-cycle pulse when a complete command byte plus stop bit is accepted.
REQ-007 SHALL have port: cmd_byte  output  8  last accepted command, stable from cmd_valid until the next one.
REQ-008 SHALL have port: busy  output  1  high in every state except IDLE.

Function
REQ-009 SHALL pass JB through a two-flop synchronizer and act only on the synchronized level and its falling edge.
REQ-010 SHALL use states IDLE, RX_BIT, RX_STOP, TURN, TX_BIT, TX_STOP, ERR_WAIT.
REQ-011 IDLE: a falling edge SHALL start bit 7 in RX_BIT with the bit counter cleared.
REQ-012 RX_BIT: the bit value SHALL be the synchronized level sampled 2*US_CYC cycles after the falling edge (high=1, low=0), shifted in MSB first.
REQ-013 RX_BIT: after a sampled bit, a falling edge SHALL start the next bit; no falling edge within 4*US_CYC of the previous one SHALL go to ERR_WAIT.
REQ-014 After 8 bits, RX_STOP SHALL accept a falling edge followed by a release within 3*US_CYC as the stop bit; otherwise ERR_WAIT.
REQ-015 On stop-bit release, cmd_valid SHALL pulse and cmd_byte update in the same cycle; the next state SHALL be TURN for known commands and IDLE for any other code.
REQ-016 Known commands SHALL be 0x00 (info), 0xFF (reset/info) -> reply 0x05 0x00 0x02; 0x01 (poll) -> reply cntlr_data[31:0].
REQ-017 TURN SHALL last exactly 2*US_CYC cycles; on its final cycle cntlr_data SHALL be snapshotted, and later changes SHALL NOT affect the reply.
REQ-018 TX_BIT: each bit SHALL be 4*US_CYC cycles: drive low US_CYC then release 3*US_CYC for 1; drive low 3*US_CYC then release US_CYC for 0.
REQ-019 TX_STOP SHALL drive low 2*US_CYC, release, then return to IDLE; received edges SHALL be ignored during TURN, TX_BIT and TX_STOP.
REQ-020 ERR_WAIT SHALL release JB and return to IDLE only after the line has been continuously high for 8*US_CYC cycles.
REQ-021 Any line low longer than 4*US_CYC during RX_BIT or RX_STOP SHALL go to ERR_WAIT.
REQ-022 Counters SHALL be sized to hold 8*US_CYC without wrap; the bit counter SHALL cover 0..31.

Reset
REQ-023 With rst_n low at a clock edge: state=IDLE, JB released ('z), cmd_valid=0, cmd_byte=0x00, busy=0, synchronizer flops=1, all counters and shift registers 0.
REQ-024 Reset mid-transmission SHALL release JB on the first clock edge at which rst_n is sampled low, with no partial stop bit.

Configuration
REQ-025 With JOYBUS_DEV_ERR_EN defined, an extra output err_cnt [7:0] SHALL increment, saturating at 0xFF, on each ERR_WAIT entry and each unknown command, and reset to 0.
REQ-026 Without JOYBUS_DEV_ERR_EN, err_cnt and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-027 The shared package joybus_pkg SHALL hold command codes (0x00, 0x01, 0xFF), info reply bytes 0x05/0x00/0x02, the state enum and the timing multiples (1, 2, 3, 4, 8 us).
REQ-028 The synchronizer and falling-edge detector SHALL be a sub-module joybus_line_sync, reusable by the host side.

Verification (CLK_FREQ_HZ=50_000_000, US_CYC=50)
REQ-029 Host sends 0x01 + stop, cntlr_data=0x8000_7F01 -> cmd_valid pulse, cmd_byte=0x01; after 100 cycles, 32 bits 0x80007F01 of 200 cycles each, then 100-cycle stop low.
REQ-030 Host sends 0x00 -> reply bits 0x05,0x00,0x02 (24 bits) + stop; repeat with 0xFF -> identical reply.
REQ-031 Host sends 0x41 -> cmd_valid, cmd_byte=0x41, no JB drive, busy low next cycle, err_cnt=1 (macro on).
REQ-032 Host stops after 5 bits -> ERR_WAIT 200 cycles after the last edge, IDLE after 400 high cycles, no reply, err_cnt increments.
REQ-033 cntlr_data changed during TX_BIT -> reply unchanged; rst_n low during bit 10 -> JB 'z next edge, all outputs at reset values.
REQ-034 Line held low 300 cycles mid-byte -> ERR_WAIT; a following valid 0x01 command -> correct reply.

Source files
------------

// File: rtl/joybus_pkg.sv
// Shared JOYBUS definitions: command codes, info reply bytes, FSM states and
// the bus timing expressed in microseconds.
package joybus_pkg;

  // Command codes understood by the device
  localparam logic [7:0] CmdInfo  = 8'h00;
  localparam logic [7:0] CmdPoll  = 8'h01;
  localparam logic [7:0] CmdReset = 8'hFF;

  // Reply to info / reset: device type and status
  localparam logic [7:0] InfoByte0 = 8'h05;
  localparam logic [7:0] InfoByte1 = 8'h00;
  localparam logic [7:0] InfoByte2 = 8'h02;

  // Timing multiples in microseconds
  localparam int unsigned T1Us = 1;
  localparam int unsigned T2Us = 2;
  localparam int unsigned T3Us = 3;
  localparam int unsigned T4Us = 4;
  localparam int unsigned T8Us = 8;

  typedef enum logic [2:0] {
    StIdle,
    StRxBit,
    StRxStop,
    StTurn,
    StTxBit,
    StTxStop,
    StErrWait
  } state_e;

  function automatic logic cmd_known(input logic [7:0] code);
    return (code == CmdInfo) || (code == CmdPoll) || (code == CmdReset);
  endfunction

endpackage

// File: rtl/joybus_if.sv
// Controller-side signals of the JOYBUS device. The optional error counter is
// present only when JOYBUS_DEV_ERR_EN is defined.
interface joybus_if;

  logic [31:0] cntlr_data;
  logic        cmd_valid;
  logic [7:0]  cmd_byte;
  logic        busy;
`ifdef JOYBUS_DEV_ERR_EN
  logic [7:0]  err_cnt;
`endif

  // Device side
  modport slave (
    input  cntlr_data,
`ifdef JOYBUS_DEV_ERR_EN
    output err_cnt,
`endif
    output cmd_valid,
    output cmd_byte,
    output busy
  );

  // Consumer side
  modport master (
    output cntlr_data,
`ifdef JOYBUS_DEV_ERR_EN
    input  err_cnt,
`endif
    input  cmd_valid,
    input  cmd_byte,
    input  busy
  );

endinterface

// File: rtl/joybus_line_sync.sv
// Two-flop synchronizer for the open-drain line plus a falling-edge detector
// on the synchronized level. Usable on either end of the bus.
module joybus_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic line,
  output logic level,
  output logic fall
);

  // [0],[1]: synchronizer stages, [2]: previous synchronized level
  logic [2:0] sync_q;

  // Shift the raw line through; idle bus is high so reset to ones
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= 3'b111;
    end else begin
      sync_q <= {sync_q[1:0], line};
    end
  end

  assign level = sync_q[1];
  assign fall  = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/joybus_device.sv
// JOYBUS controller-side device: receives a command byte from the host,
// answers info/reset with 0x05 0x00 0x02 and poll with cntlr_data.
// Optional feature macro: JOYBUS_DEV_ERR_EN adds a saturating err_cnt output.
module joybus_device
  import joybus_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
  input  logic    clk,
  input  logic    rst_n,
  inout  wire     JB,
  joybus_if.slave bus
);

  localparam int unsigned US_CYC = CLK_FREQ_HZ / 1_000_000;
  localparam int unsigned TmrW   = $clog2(T8Us * US_CYC + 1);

  typedef logic [TmrW-1:0] tmr_t;

  localparam tmr_t Tick1   = tmr_t'(T1Us * US_CYC);
  localparam tmr_t Tick2   = tmr_t'(T2Us * US_CYC);
  localparam tmr_t Tick3   = tmr_t'(T3Us * US_CYC);
  localparam tmr_t Tick4   = tmr_t'(T4Us * US_CYC);
  localparam tmr_t Tick2M1 = tmr_t'(T2Us * US_CYC - 1);
  localparam tmr_t Tick4M1 = tmr_t'(T4Us * US_CYC - 1);
  localparam tmr_t Tick8M1 = tmr_t'(T8Us * US_CYC - 1);

  logic level;
  logic fall;

  state_e      state_q, state_d;
  tmr_t        tmr_q, tmr_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [4:0]  tx_last_q, tx_last_d;
  logic        sampled_q, sampled_d;
  logic        stop_seen_q, stop_seen_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [31:0] tx_shift_q, tx_shift_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [7:0]  cmd_byte_q, cmd_byte_d;
  logic        rx_err;
  logic        drive_low;

  joybus_line_sync u_line_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .line  (JB),
    .level (level),
    .fall  (fall)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      tmr_q       <= '0;
      bit_cnt_q   <= '0;
      tx_last_q   <= '0;
      sampled_q   <= 1'b0;
      stop_seen_q <= 1'b0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      cmd_valid_q <= 1'b0;
      cmd_byte_q  <= '0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_last_q   <= tx_last_d;
      sampled_q   <= sampled_d;
      stop_seen_q <= stop_seen_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_byte_q  <= cmd_byte_d;
    end
  end

  // Next-state logic: receive, turnaround, transmit and error recovery
  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    bit_cnt_d   = bit_cnt_q;
    tx_last_d   = tx_last_q;
    sampled_d   = sampled_q;
    stop_seen_d = stop_seen_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    cmd_valid_d = 1'b0;
    cmd_byte_d  = cmd_byte_q;
    rx_err      = 1'b0;

    unique case (state_q)
      StIdle: begin
        tmr_d = '0;
        if (fall) begin
          state_d    = StRxBit;
          tmr_d      = tmr_t'(1);
          bit_cnt_d  = '0;
          sampled_d  = 1'b0;
          rx_shift_d = '0;
        end
      end

      // tmr counts cycles since the falling edge that opened the current bit
      StRxBit: begin
        tmr_d = tmr_q + tmr_t'(1);
        if (!sampled_q) begin
          if (tmr_q == Tick2) begin
            rx_shift_d = {rx_shift_q[6:0], level};
            sampled_d  = 1'b1;
            if (bit_cnt_q == 5'd7) begin
              state_d     = StRxStop;
              stop_seen_d = 1'b0;
            end
          end
        end else if (fall) begin
          tmr_d     = tmr_t'(1);
          sampled_d = 1'b0;
          bit_cnt_d = bit_cnt_q + 5'd1;
        end else if (tmr_q >= Tick4) begin
          rx_err = 1'b1;
        end
      end

      StRxStop: begin
        tmr_d = tmr_q + tmr_t'(1);
        if (!stop_seen_q) begin
          if (fall) begin
            tmr_d       = tmr_t'(1);
            stop_seen_d = 1'b1;
          end else if (tmr_q >= Tick4) begin
            rx_err = 1'b1;
          end
        end else if (level) begin
          cmd_valid_d = 1'b1;
          cmd_byte_d  = rx_shift_q;
          tmr_d       = '0;
          state_d     = cmd_known(rx_shift_q) ? StTurn : StIdle;
        end else if (tmr_q >= Tick3) begin
          rx_err = 1'b1;
        end
      end

      // Reply payload is captured on the last turnaround cycle
      StTurn: begin
        tmr_d = tmr_q + tmr_t'(1);
        if (tmr_q == Tick2M1) begin
          state_d   = StTxBit;
          tmr_d     = '0;
          bit_cnt_d = '0;
          if (cmd_byte_q == CmdPoll) begin
            tx_shift_d = bus.cntlr_data;
            tx_last_d  = 5'd31;
          end else begin
            tx_shift_d = {InfoByte0, InfoByte1, InfoByte2, 8'h00};
            tx_last_d  = 5'd23;
          end
        end
      end

      StTxBit: begin
        tmr_d = tmr_q + tmr_t'(1);
        if (tmr_q == Tick4M1) begin
          tmr_d = '0;
          if (bit_cnt_q == tx_last_q) begin
            state_d = StTxStop;
          end else begin
            bit_cnt_d  = bit_cnt_q + 5'd1;
            tx_shift_d = {tx_shift_q[30:0], 1'b0};
          end
        end
      end

      StTxStop: begin
        tmr_d = tmr_q + tmr_t'(1);
        if (tmr_q == Tick2M1) begin
          state_d = StIdle;
          tmr_d   = '0;
        end
      end

      // Leave only after an unbroken high stretch
      StErrWait: begin
        if (level) begin
          tmr_d = tmr_q + tmr_t'(1);
          if (tmr_q == Tick8M1) begin
            state_d = StIdle;
            tmr_d   = '0;
          end
        end else begin
          tmr_d = '0;
        end
      end

      default: state_d = StIdle;
    endcase

    if (rx_err) begin
      state_d = StErrWait;
      tmr_d   = '0;
    end
  end

  // Open-drain drive: low phase of each reply bit and the whole stop bit
  always_comb begin
    drive_low = 1'b0;
    case (state_q)
      StTxBit:  drive_low = tx_shift_q[31] ? (tmr_q < Tick1) : (tmr_q < Tick3);
      StTxStop: drive_low = 1'b1;
      default:  drive_low = 1'b0;
    endcase
  end

  assign JB            = drive_low ? 1'b0 : 1'bz;
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd_byte  = cmd_byte_q;
  assign bus.busy      = (state_q != StIdle);

`ifdef JOYBUS_DEV_ERR_EN
  logic       err_inc;
  logic [7:0] err_cnt_q;

  assign err_inc = ((state_d == StErrWait) && (state_q != StErrWait)) ||
                   (cmd_valid_d && !cmd_known(cmd_byte_d));

  // Saturating count of error entries and unknown commands
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (err_inc && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign bus.err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_joybus_device.sv
// Scoreboard bench for joybus_device: a host model drives commands on the
// pulled-up line, expectations are queued, and two monitors decode cmd_valid
// and the device reply waveform independently of the stimulus.
module tb_joybus_device;
  import joybus_pkg::*;

  localparam int unsigned ClkFreqHz = 50_000_000;
  localparam int Us = ClkFreqHz / 1_000_000;

  typedef struct {
    logic [7:0] code;
    logic       known;
  } cmd_exp_t;

  typedef struct {
    int          nbits;
    logic [31:0] val;
  } reply_exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic host_low = 1'b0;
  wire  jb;

  pullup (jb);
  assign jb = host_low ? 1'b0 : 1'bz;

  joybus_if bus ();

  joybus_device #(
    .CLK_FREQ_HZ (ClkFreqHz)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .JB    (jb),
    .bus   (bus)
  );

  always #10 clk = ~clk;

  cmd_exp_t   cmd_q[$];
  reply_exp_t reply_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int cmd_cyc = 0;
  int exp_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: what the device must answer for a command
  function automatic reply_exp_t model_reply(input logic [7:0] code, input logic [31:0] data);
    reply_exp_t r;
    r.nbits = 0;
    r.val   = '0;
    if (code == 8'h01) begin
      r.nbits = 32;
      r.val   = data;
    end else if (code == 8'h00 || code == 8'hFF) begin
      r.nbits = 24;
      r.val   = 32'h0005_0002;
    end
    return r;
  endfunction

  // Host drive changes 5 time units after a rising edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #5;
  endtask

  task automatic host_bit(input logic b);
    host_low = 1'b1;
    tick(b ? Us : 3 * Us);
    host_low = 1'b0;
    tick(b ? 3 * Us : Us);
  endtask

  task automatic send_cmd(input logic [7:0] code, input int nbits, input bit stop);
    for (int i = 0; i < nbits; i++) host_bit(code[7-i]);
    if (stop) begin
      host_low = 1'b1;
      tick(Us);
      host_low = 1'b0;
    end
  endtask

  task automatic issue_cmd(input logic [7:0] code, input logic [31:0] data, input bit want_reply);
    reply_exp_t r;
    cmd_exp_t   c;
    r = model_reply(code, data);
    c.code  = code;
    c.known = (r.nbits != 0);
    cmd_q.push_back(c);
    if (want_reply && r.nbits != 0) reply_q.push_back(r);
    if (r.nbits == 0) exp_err++;
    bus.cntlr_data = data;
    send_cmd(code, 8, 1'b1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    tick(10);
    while (bus.busy && n < 12000) begin
      tick(1);
      n++;
    end
    n_checks++;
    if (bus.busy) begin
      n_fail++;
      $display("FAIL %s_idle_timeout: busy=1 after %0d cycles, required 0", name, n);
    end
    tick(20);
  endtask

  task automatic check_err(input string name);
`ifdef JOYBUS_DEV_ERR_EN
    check(name, bus.err_cnt, exp_err);
`else
    if (name.len() == 0) $display("unnamed err check");
`endif
  endtask

  // Command monitor
  cmd_exp_t ce;
  always @(negedge clk) begin
    if (rst_n && bus.cmd_valid) begin
      cmd_cyc = cyc;
      if (cmd_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL cmd_unexpected: got cmd_byte 0x%0h, required no command", bus.cmd_byte);
      end else begin
        ce = cmd_q.pop_front();
        check("cmd_byte", bus.cmd_byte, ce.code);
        check("busy_at_cmd", bus.busy, ce.known);
      end
    end
  end

  // Reply monitor: decodes device-driven low pulses into bits and frames
  int          lo_len = 0;
  int          prev_start = 0;
  int          rx_n = 0;
  logic [31:0] rx_acc = '0;
  bit          in_frame = 1'b0;
  reply_exp_t  re;
  always @(negedge clk) begin
    if (!rst_n) begin
      lo_len   = 0;
      rx_n     = 0;
      rx_acc   = '0;
      in_frame = 1'b0;
    end else if (jb === 1'b0 && !host_low) begin
      if (lo_len == 0) begin
        if (!in_frame) check("turnaround", cyc - cmd_cyc, 2 * Us);
        else check("bit_period", cyc - prev_start, 4 * Us);
        prev_start = cyc;
        in_frame   = 1'b1;
      end
      lo_len++;
    end else if (lo_len != 0) begin
      if (lo_len == Us || lo_len == 3 * Us) begin
        rx_acc = {rx_acc[30:0], (lo_len == Us)};
        rx_n++;
      end else begin
        check("stop_len", lo_len, 2 * Us);
        if (reply_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL reply_unexpected: got %0d bits 0x%0h, required no reply", rx_n, rx_acc);
        end else begin
          re = reply_q.pop_front();
          check("reply_bits", rx_n, re.nbits);
          check("reply_data", rx_acc, re.val);
        end
        rx_n     = 0;
        rx_acc   = '0;
        in_frame = 1'b0;
      end
      lo_len = 0;
    end
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: still running after 95000 cycles, required completion");
    $fatal(1, "watchdog expired");
  end

  logic [7:0]  code;
  logic [31:0] data;
  int          t0;
  int          d;
  int          n;

  initial begin
    bus.cntlr_data = '0;
    tick(5);
    @(negedge clk);
    check("rst_jb", jb, 1);
    check("rst_cmd_valid", bus.cmd_valid, 0);
    check("rst_cmd_byte", bus.cmd_byte, 0);
    check("rst_busy", bus.busy, 0);
    check_err("rst_err_cnt");
    rst_n = 1'b1;
    tick(20);

    // Poll with a fixed word
    issue_cmd(8'h01, 32'h8000_7F01, 1'b1);
    wait_idle("poll");

    // Info and reset/info
    issue_cmd(8'h00, $urandom, 1'b1);
    wait_idle("info");
    issue_cmd(8'hFF, $urandom, 1'b1);
    wait_idle("reset_info");

    // Unknown command
    issue_cmd(8'h41, $urandom, 1'b1);
    wait_idle("unknown");
    check_err("err_cnt_unknown");

    // Host stops after five bits
    code = 8'($urandom);
    send_cmd(code, 4, 1'b0);
    t0 = cyc;
    host_bit(code[3]);
    n = 0;
    while (bus.busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    d = cyc - t0;
    check("err_recover_window", (d >= 12 * Us && d <= 12 * Us + 8) ? 1 : 0, 1);
    exp_err++;
    tick(20);
    check_err("err_cnt_short");

    // Controller word changes while the reply is in flight
    data = $urandom;
    issue_cmd(8'h01, data, 1'b1);
    tick(1000);
    bus.cntlr_data = ~data;
    wait_idle("poll_snapshot");

    // Reset while bit 10 of a poll reply is being driven low
    issue_cmd(8'h01, $urandom, 1'b0);
    tick(2110);
    @(negedge clk);
    check("pre_reset_drive", jb, 0);
    rst_n = 1'b0;
    @(negedge clk);
    exp_err = 0;
    check("midrst_jb", jb, 1);
    check("midrst_cmd_valid", bus.cmd_valid, 0);
    check("midrst_cmd_byte", bus.cmd_byte, 0);
    check("midrst_busy", bus.busy, 0);
    check_err("midrst_err_cnt");
    tick(5);
    rst_n = 1'b1;
    tick(20);

    // Line held low mid-byte, then a good poll
    send_cmd(8'($urandom), 3, 1'b0);
    host_low = 1'b1;
    tick(300);
    host_low = 1'b0;
    exp_err++;
    wait_idle("held_low");
    issue_cmd(8'h01, $urandom, 1'b1);
    wait_idle("poll_after_err");
    check_err("err_cnt_held_low");

    // Random commands
    for (int i = 0; i < 2; i++) begin
      case ($urandom_range(0, 3))
        0:       code = 8'h00;
        1:       code = 8'h01;
        2:       code = 8'hFF;
        default: code = 8'($urandom);
      endcase
      issue_cmd(code, $urandom, 1'b1);
      wait_idle("random");
      check_err("err_cnt_random");
    end

    check("cmd_q_drained", cmd_q.size(), 0);
    check("reply_q_drained", reply_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
